// File: rtl/vco_adc_scheduler.sv
// Round-robin conversion sequencer for the VCO ADC channels with a small result FIFO.
// Optional build macro VCO_ADC_SCHED_DROP_EN: drop results on a full FIFO instead of stalling.
module vco_adc_scheduler #(
   parameter int NCH        = 3,
   parameter int CHW        = 2,
   parameter int CW         = 16,
   parameter int WW         = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                cfg_go,
   input  logic                cfg_single,
   input  logic [NCH-1:0]      cfg_ch_mask,
   input  logic [7:0]          cfg_settle,
   input  logic [WW-1:0]       cfg_window,
   input  logic [NCH*CW-1:0]   ch_count,
   output logic [NCH-1:0]      vco_en,
   output logic                cnt_clr,
   output logic                cnt_latch,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [CHW+CW-1:0]   res_data,
   output logic                busy,
   output logic                sweep_done,
   output logic                overflow
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] FULL_OCC = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, SETTLE, WINDOW, CAPTURE, PUSH} state_t;

   state_t             state;
   logic [CHW-1:0]     ch;
   logic [CHW-1:0]     rr;
   logic [CHW-1:0]     rr_next;
   logic [WW-1:0]      cnt;
   logic [WW-1:0]      win_last;
   logic               run_q;
   logic               go_d;
   logic               run_ok;
   logic               run_cont;
   logic               sweep_end;
   logic [NCH-1:0]     mask_above;
   logic [CHW:0]       sel_idle;
   logic [CHW:0]       sel_push;
   logic [CW-1:0]      cap_count;
   logic [CHW+CW-1:0]  mem [FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [AW:0]        occ;
   logic               full;
   logic               pop;
   logic               push_ok;
   logic               fifo_wr;
   logic               advance;

   // Returns {found, channel}: lowest enabled channel at or after start, wrapping.
   function automatic logic [CHW:0] pick_ch(input logic [NCH-1:0] mask,
                                            input logic [CHW-1:0] start);
      logic [2*NCH-1:0] dbl;
      logic [CHW:0]     s;
      logic [CHW:0]     res;
      dbl = {mask, mask} >> start;
      res = '0;
      for (int i = NCH-1; i >= 0; i--) begin
         if (dbl[i]) begin
            s = {1'b0, start} + (CHW+1)'(i);
            if (s >= (CHW+1)'(NCH)) s = s - (CHW+1)'(NCH);
            res = {1'b1, s[CHW-1:0]};
         end
      end
      return res;
   endfunction

   assign run_ok     = cfg_go && (!cfg_single || run_q);
   assign win_last   = (cfg_window == '0) ? '0 : cfg_window - 1'b1;
   assign rr_next    = (ch == CHW'(NCH-1)) ? '0 : ch + 1'b1;
   assign mask_above = (cfg_ch_mask >> ch) >> 1;
   assign sweep_end  = (mask_above == '0);
   assign run_cont   = run_ok && !(cfg_single && sweep_end);
   assign sel_idle   = pick_ch(cfg_ch_mask, rr);
   assign sel_push   = pick_ch(cfg_ch_mask, rr_next);
   assign busy       = (state != IDLE);

   assign full      = (occ == FULL_OCC);
   assign res_valid = (occ != '0);
   assign pop       = res_valid && res_ready;
   assign push_ok   = !full || pop;
   assign fifo_wr   = (state == PUSH) && push_ok;
   assign res_data  = res_valid ? mem[rd_ptr] : '0;

`ifdef VCO_ADC_SCHED_DROP_EN
   assign advance = (state == PUSH);

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) overflow <= 1'b0;
      else if ((state == PUSH) && !push_ok) overflow <= 1'b1;
   end
`else
   assign advance  = fifo_wr;
   assign overflow = 1'b0;
`endif

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state      <= IDLE;
         ch         <= '0;
         rr         <= '0;
         cnt        <= '0;
         run_q      <= 1'b0;
         go_d       <= 1'b0;
         vco_en     <= '0;
         cnt_clr    <= 1'b0;
         cnt_latch  <= 1'b0;
         sweep_done <= 1'b0;
      end else begin
         go_d       <= cfg_go;
         cnt_clr    <= 1'b0;
         sweep_done <= 1'b0;
         if (!cfg_go)                                  run_q <= 1'b0;
         else if (!go_d)                               run_q <= 1'b1;
         else if ((state == PUSH) && advance && sweep_end) run_q <= 1'b0;

         case (state)
            IDLE: begin
               if (run_ok && sel_idle[CHW]) begin
                  state   <= SETTLE;
                  ch      <= sel_idle[CHW-1:0];
                  vco_en  <= NCH'(1) << sel_idle[CHW-1:0];
                  cnt_clr <= 1'b1;
                  cnt     <= WW'(cfg_settle);
               end
            end
            SETTLE: begin
               if (cnt == '0) begin
                  state     <= WINDOW;
                  cnt       <= win_last;
                  cnt_latch <= (win_last == '0);
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            WINDOW: begin
               if (cnt == '0) begin
                  state     <= CAPTURE;
                  vco_en    <= '0;
                  cnt_latch <= 1'b0;
               end else begin
                  cnt       <= cnt - 1'b1;
                  cnt_latch <= (cnt == WW'(1));
               end
            end
            CAPTURE: state <= PUSH;
            PUSH: begin
               // Back-to-back conversions reuse this cycle as the next selection cycle.
               if (advance) begin
                  rr         <= rr_next;
                  sweep_done <= sweep_end;
                  if (run_cont && sel_push[CHW]) begin
                     state   <= SETTLE;
                     ch      <= sel_push[CHW-1:0];
                     vco_en  <= NCH'(1) << sel_push[CHW-1:0];
                     cnt_clr <= 1'b1;
                     cnt     <= WW'(cfg_settle);
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (state == CAPTURE) cap_count <= ch_count[ch*CW +: CW];
      if (fifo_wr)          mem[wr_ptr] <= {ch, cap_count};
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({fifo_wr, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: tb/tb_vco_adc_scheduler.sv
// Scoreboard bench for vco_adc_scheduler: a channel-order model predicts conversions and FIFO entries.
module tb_vco_adc_scheduler;
   localparam int NCH = 3, CHW = 2, CW = 16, WW = 16, FIFO_DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              go = 1'b0;
   logic              single = 1'b0;
   logic [NCH-1:0]    mask = '0;
   logic [7:0]        settle = '0;
   logic [WW-1:0]     window = '0;
   logic [NCH*CW-1:0] counts = '0;
   logic              res_ready = 1'b0;
   logic [NCH-1:0]    vco_en;
   logic              cnt_clr, cnt_latch, res_valid, busy, sweep_done, overflow;
   logic [CHW+CW-1:0] res_data;

   int tests = 0, fails = 0;
   int cyc = 0, clr_total = 0, sweep_cnt = 0, last_clr = 0, mon_t, mon_c;
   int model_rr = 0;
   bit lat_chk = 1'b1;
   int conv_q[$];
   int clr_cyc_q[$];
   logic [CHW+CW-1:0] exp_q[$];

   vco_adc_scheduler #(.NCH(NCH), .CHW(CHW), .CW(CW), .WW(WW), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .cfg_go(go), .cfg_single(single),
      .cfg_ch_mask(mask), .cfg_settle(settle), .cfg_window(window), .ch_count(counts),
      .vco_en(vco_en), .cnt_clr(cnt_clr), .cnt_latch(cnt_latch), .res_valid(res_valid),
      .res_ready(res_ready), .res_data(res_data), .busy(busy), .sweep_done(sweep_done),
      .overflow(overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int win_eff();
      return (window == '0) ? 1 : int'(window);
   endfunction

   function automatic bit enabled(input int c);
      return ((int'(mask) >> c) & 1) != 0;
   endfunction

   function automatic int next_sel(input int start);
      int c = -1;
      for (int i = NCH-1; i >= 0; i--)
         if (enabled((start + i) % NCH)) c = (start + i) % NCH;
      return c;
   endfunction

   task automatic model_conv(input int c, input bit stored);
      conv_q.push_back(c);
      if (stored) exp_q.push_back({CHW'(c), counts[c*CW +: CW]});
      model_rr = (c + 1) % NCH;
   endtask

   // One sweep: first enabled channel from the pointer, then every enabled channel above it.
   task automatic model_sweep();
      int c, nxt;
      c = next_sel(model_rr);
      while (c >= 0) begin
         model_conv(c, 1'b1);
         nxt = -1;
         for (int k = NCH-1; k > c; k--) if (enabled(k)) nxt = k;
         c = nxt;
      end
   endtask

   task automatic clear_model();
      conv_q.delete();
      exp_q.delete();
      clr_cyc_q.delete();
   endtask

   task automatic rand_counts();
      for (int i = 0; i < NCH; i++) counts[i*CW +: CW] = CW'($urandom);
   endtask

   task automatic wait_busy(input logic lvl, input int budget, input string name);
      int n = 0;
      while (busy !== lvl && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(busy), 32'(lvl));
   endtask

   task automatic run_single(input logic [NCH-1:0] m, input int s, input int w);
      int sw0;
      @(posedge clk); #1;
      go = 1'b0; single = 1'b1; res_ready = 1'b1; lat_chk = 1'b1;
      mask = m; settle = 8'(s); window = WW'(w);
      clr_cyc_q.delete();
      model_sweep();
      sw0 = sweep_cnt;
      @(posedge clk); #1;
      go = 1'b1;
      wait_busy(1'b1, 10, "single_start");
      wait_busy(1'b0, 2000, "single_end_idle");
      repeat (3) @(posedge clk);
      #1;
      check("sweep_done_count", 32'(sweep_cnt - sw0), 32'd1);
      check("single_queue_drained", 32'(exp_q.size()), 32'd0);
      check("single_conv_done", 32'(conv_q.size()), 32'd0);
      go = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (cnt_clr) begin
            clr_total++;
            last_clr = cyc;
            clr_cyc_q.push_back(cyc);
            if (conv_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_conversion: vco_en=%b, none predicted", vco_en);
            end else begin
               mon_c = conv_q.pop_front();
               check("vco_en_onehot", 32'(vco_en), 32'd1 << mon_c);
            end
         end
         if (cnt_latch) check("clr_to_latch", 32'(cyc - last_clr), 32'(int'(settle) + win_eff()));
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_entry: res_data=0x%0h, none predicted", res_data);
            end else begin
               check("res_data", 32'(res_data), 32'(exp_q.pop_front()));
            end
            if (clr_cyc_q.size() > 0) begin
               mon_t = clr_cyc_q.pop_front();
               if (lat_chk) check("entry_latency", 32'(cyc - mon_t), 32'(int'(settle) + win_eff() + 3));
            end
         end
         if (sweep_done) sweep_cnt++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, c;
      rand_counts();
      repeat (3) @(posedge clk);
      #1;
      check("rst_vco_en", 32'(vco_en), 32'd0);
      check("rst_cnt_clr", 32'(cnt_clr), 32'd0);
      check("rst_cnt_latch", 32'(cnt_latch), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_data", 32'(res_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_sweep_done", 32'(sweep_done), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      rst = 1'b0;

      // Reset while a window is in progress.
      mask = 3'b111; settle = 8'd1; window = WW'(20); single = 1'b0; res_ready = 1'b1;
      conv_q.push_back(0);
      go = 1'b1;
      base = 0;
      while (clr_total < 1 && base < 20) begin @(negedge clk); base++; end
      check("t1_first_clr", 32'(clr_total), 32'd1);
      repeat (6) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("t1_rst_vco_en", 32'(vco_en), 32'd0);
      check("t1_rst_res_valid", 32'(res_valid), 32'd0);
      check("t1_rst_busy", 32'(busy), 32'd0);
      go = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      clear_model();
      model_rr = 0;
      rst = 1'b0;
      run_single(3'b111, int'($urandom_range(0, 4)), int'($urandom_range(1, 8)));

      // Fixed sweep over channels 0 and 2.
      rand_counts();
      counts[0*CW +: CW] = 16'h1234;
      counts[2*CW +: CW] = 16'h0ABC;
      run_single(3'b101, 2, 10);

      // Minimum timing: settle 0, window 0.
      rand_counts();
      run_single(3'(($urandom_range(1, 7))), 0, 0);

      for (int i = 0; i < 6; i++) begin
         rand_counts();
         run_single(3'($urandom_range(1, 7)), int'($urandom_range(0, 6)), int'($urandom_range(0, 15)));
      end

      // Full FIFO with the consumer stalled.
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      clear_model();
      model_rr = 0;
      mask = 3'b111; settle = 8'd1; window = WW'(3); single = 1'b0; res_ready = 1'b0; lat_chk = 1'b0;
      rand_counts();
      for (int i = 0; i < 5; i++) begin
         c = next_sel(model_rr);
`ifdef VCO_ADC_SCHED_DROP_EN
         model_conv(c, i < FIFO_DEPTH);
`else
         model_conv(c, 1'b1);
`endif
      end
      base = clr_total;
      go = 1'b1;
      c = 0;
      while (clr_total < base + 5 && c < 200) begin @(negedge clk); c++; end
      check("t3_fifth_conv", 32'(clr_total - base), 32'd5);
      @(posedge clk); #1;
      go = 1'b0;
      repeat (30) @(posedge clk);
      #1;
`ifdef VCO_ADC_SCHED_DROP_EN
      check("t3_drop_idle", 32'(busy), 32'd0);
      check("t3_overflow_set", 32'(overflow), 32'd1);
`else
      check("t3_stall_busy", 32'(busy), 32'd1);
      check("t3_stall_vco_off", 32'(vco_en), 32'd0);
      check("t3_overflow_zero", 32'(overflow), 32'd0);
`endif
      check("t3_res_valid", 32'(res_valid), 32'd1);
      res_ready = 1'b1;
      wait_busy(1'b0, 50, "t3_idle_after_drain");
      repeat (6) @(posedge clk);
      #1;
      check("t3_entries_drained", 32'(exp_q.size()), 32'd0);
      check("t3_fifo_empty", 32'(res_valid), 32'd0);
`ifdef VCO_ADC_SCHED_DROP_EN
      check("t3_overflow_sticky", 32'(overflow), 32'd1);
`endif

      // Run dropped while channel 1 is counting.
      mask = 3'b111; settle = 8'd1; window = WW'(8); single = 1'b0; res_ready = 1'b1; lat_chk = 1'b1;
      clr_cyc_q.delete();
      rand_counts();
      do begin
         c = next_sel(model_rr);
         model_conv(c, 1'b1);
      end while (c != 1);
      go = 1'b1;
      c = 0;
      while (conv_q.size() != 0 && c < 200) begin @(negedge clk); c++; end
      check("t6_ch1_started", 32'(conv_q.size()), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      go = 1'b0;
      wait_busy(1'b0, 60, "t6_idle");
      base = clr_total;
      repeat (30) @(posedge clk);
      #1;
      check("t6_no_further_conv", 32'(clr_total), 32'(base));
      check("t6_still_idle", 32'(busy), 32'd0);
      check("t6_entries_done", 32'(exp_q.size()), 32'd0);
      check("t6_vco_off", 32'(vco_en), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
